pipelined_add_sub: RTL
======================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised, pipelined adder/subtractor with carry-in, carry-out and signed overflow.
//  Splits the carry chain into STAGES equal slices, with one register stage per slice.
//  Uses a valid/ready handshake on both sides and accepts one operation per cycle.
//  Arithmetic building block for wide datapaths where a single-cycle ripple chain misses timing.
// PARAMETERS
//  WIDTH   16  operand/result width in bits
//  STAGES   4  number of pipeline stages = carry slices; WIDTH % STAGES must be 0, STAGES >= 1
// PORTS
//  clk_in         in   1      clock; all state updates on rising edge
//  rst_in         in   1      asynchronous, active-high reset
//  valid_in       in   1      input operation valid
//  ready_out      out  1      block can accept an input this cycle
//  a_in           in   WIDTH  operand A (unsigned or two's complement)
//  b_in           in   WIDTH  operand B
//  c_in           in   1      add: carry-in; sub: borrow-in
//  sub_in         in   1      0 = A+B+c_in, 1 = A-B-c_in
//  valid_out      out  1      result valid
//  ready_in       in   1      downstream accepts result
//  sum_out        out  WIDTH  result
//  carry_out      out  1      raw MSB carry (sub: 1 = no borrow, 0 = borrow)
//  overflow_out   out  1      signed two's-complement overflow of the result
// BEHAVIOUR
//  - CHUNK = WIDTH/STAGES. Stage k (0..STAGES-1) adds slice k, bits [k*CHUNK +: CHUNK].
//    It uses the carry registered by stage k-1 (stage 0 uses the effective cin).
//  - Sub mode: the B operand used is ~b_in and the effective cin is ~c_in. Add mode: B = b_in, cin = c_in.
//  - Skew: operand slices not yet consumed travel with the op through the stage registers.
//    Completed result slices also travel with it, so each op's bits stay aligned.
//  - Overflow: computed in the last stage.
//    overflow_out = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
//  - Handshake: transfer in when valid_in && ready_out; transfer out when valid_out && ready_in.
//  - Global advance enable en = ready_in || !valid_out. ready_out = en (combinational).
//  - en=1: every stage register, including its valid bit, shifts one stage.
//  - en=0: all stages hold. sum_out, carry_out, overflow_out and valid_out are stable while stalled.
//  - Bubbles (valid=0 stages) propagate and are not collapsed. Throughput is 1 op/cycle with ready_in=1.
//  - Latency: an op accepted at edge t appears on valid_out after edge t+STAGES-1 (STAGES cycles).
//    This assumes no stall in between; each stalled cycle adds one.
//  - STAGES=1 degenerates to a single registered WIDTH-bit add/sub with latency 1.
//  - Inputs are ignored while valid_in=0 or ready_out=0; sub_in and c_in are sampled per op.
//  - Modes may change every op; add and sub ops may be interleaved freely.
//  - Reset (async, any time): all stage valid bits = 0, all data/carry regs = 0.
//    valid_out=0, sum_out=0, carry_out=0, overflow_out=0 immediately. In-flight ops are discarded.
//    ready_out=1 while rst_in is low and no valid data is stalled.
//  - Invalid parameters (WIDTH % STAGES != 0 or STAGES < 1) are an elaboration-time error.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  1. add 0x00FF+0x0001, c_in=0 -> sum 0x0100, carry 0, ovf 0, valid_out 4 cycles after accept.
//     Also 0xFFFF+0x0001 -> 0x0000, carry 1, ovf 0. Also 0x7FFF+0x0001 -> 0x8000, ovf 1.
//  2. sub 0x0005-0x0007, c_in=0 -> 0xFFFE, carry 0, ovf 0.
//     sub 0x8000-0x0001 -> 0x7FFF, ovf 1. sub 0x0010-0x0003, c_in=1 -> 0x000C, carry 1.
//  3. 8 back-to-back ops alternating add/sub, ready_in=1 -> 8 results in order on 8 consecutive cycles.
//  4. Same stream with ready_in=0 for 3 cycles mid-stream -> ready_out=0 while output is held.
//     No loss or duplication, outputs stable during the stall, order preserved.
//  5. rst_in pulsed with 3 ops in flight -> valid_out drops in the same cycle, outputs 0.
//     No stale result appears after release. The next op completes with normal latency.
//  6. STAGES=1 and STAGES=16, plus WIDTH=32/STAGES=4: 1000 random ops with random valid_in/ready_in.
//     Compare against a behavioural {carry,sum} = A +/- B +/- c model; zero mismatches.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: carry-sliced pipelined adder/subtractor with valid/ready handshake
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);
    localparam int CHUNK = WIDTH / (STAGES < 1 ? 1 : STAGES);

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign en        = ready_in || !valid_out;
    assign ready_out = en;
    assign b_eff     = sub_in ? ~b_in : b_in;
    assign cin_eff   = sub_in ? ~c_in : c_in;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operands shrink by one slice per stage; the result grows by one slice
        localparam int RW = WIDTH - k * CHUNK;
        logic [RW-1:0]          a_s, b_s;
        logic                   c_s, v_s;
        logic [CHUNK:0]         add;
        logic [(k+1)*CHUNK-1:0] s_n, s_q;
        logic                   c_q, v_q;
        if (k == 0) begin : g_head
            assign a_s = a_in;
            assign b_s = b_eff;
            assign c_s = cin_eff;
            assign v_s = valid_in;
            assign s_n = add[CHUNK-1:0];
        end else begin : g_tail
            assign a_s = g_st[k-1].g_fwd.a_q;
            assign b_s = g_st[k-1].g_fwd.b_q;
            assign c_s = g_st[k-1].c_q;
            assign v_s = g_st[k-1].v_q;
            assign s_n = {add[CHUNK-1:0], g_st[k-1].s_q};
        end
        assign add = {1'b0, a_s[CHUNK-1:0]} + {1'b0, b_s[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_s};
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_s;
                if (v_s) begin
                    s_q <= s_n;
                    c_q <= add[CHUNK];
                end
            end
        end
        if (k < STAGES - 1) begin : g_fwd
            logic [RW-CHUNK-1:0] a_q, b_q;
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_s) begin
                    a_q <= a_s[RW-1:CHUNK];
                    b_q <= b_s[RW-1:CHUNK];
                end
            end
        end else begin : g_ovf
            logic ovf_q;
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in)
                    ovf_q <= 1'b0;
                else if (en && v_s)
                    ovf_q <= (a_s[RW-1] == b_s[RW-1]) && (add[CHUNK-1] != a_s[RW-1]);
            end
        end
    end

    assign valid_out    = g_st[STAGES-1].v_q;
    assign sum_out      = g_st[STAGES-1].s_q;
    assign carry_out    = g_st[STAGES-1].c_q;
    assign overflow_out = g_st[STAGES-1].g_ovf.ovf_q;
endmodule
